uart_rx: RTL and testbench

- Serial receiver for 8N1 UART frames. It is the receive counterpart of the existing transmit path and shares the same baud divisor constants.
- It synchronises the raw rx pin and detects the start edge. Each bit is sampled at mid-bit using an internal mid-bit baud pulse generator.
- It presents the received byte with a one-cycle strobe and a framing-error flag.
- It sits between the board rx pin and consumers such as the CPU I/O register or a FIFO.

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/baudgen_rx.sv | 52 +++++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared UART baud divisors (clock cycles per bit at 12 MHz) and frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    // Start + 8 data + stop, all sampled into the shift register
    localparam int FRAME_BITS = 10;

    function automatic int mid_bit(input int baud);
        return baud / 2;
    endfunction

endpackage : uart_rx_pkg

`default_nettype wire

// File: rtl/baudgen_rx.sv
// ============================================================================
// Module      : baudgen_rx
// Description : Mid-bit baud pulse generator; first pulse BAUDRATE/2 cycles after enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic rstn,
    input  logic clk,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int            CW    = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(BAUDRATE - 1);
    localparam logic [CW-1:0] C_MID = CW'(mid_bit(BAUDRATE));

    generate
        if (BAUDRATE < 4) begin : g_baud_check
            $error("baudgen_rx: BAUDRATE must be >= 4");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Disabled counter is parked at zero so every enable starts a fresh bit period
    always_comb begin
        cnt_d = '0;
        if (clk_ena) begin
            cnt_d = (cnt_q == C_MAX) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_out = clk_ena && (cnt_q == C_MID);

endmodule : baudgen_rx

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling, byte strobe and framing-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       rcv,
    output logic [7:0] data,
    output logic       ferr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_LOAD = 2'd2,
        S_DAV  = 2'd3
    } state_e;

    localparam logic [3:0] C_LAST_BIT = 4'(FRAME_BITS - 1);

    state_e     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [9:0] shift_q, shift_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [7:0] data_q, data_d;
    logic       ferr_q, ferr_d;
    logic       rcv_q, rcv_d;
    logic       baud_ena;
    logic       baud_tick;

    baudgen_rx #(
        .BAUDRATE (BAUDRATE)
    ) u_baudgen (
        .rstn    (rstn),
        .clk     (clk),
        .clk_ena (baud_ena),
        .clk_out (baud_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        ferr_d   = ferr_q;
        rcv_d    = 1'b0;
        baud_ena = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d  = S_RECV;
                    bitcnt_d = 4'd0;
                end
            end
            S_RECV: begin
                baud_ena = 1'b1;
                if (baud_tick) begin
                    // A start bit that is already high at mid-bit was only a glitch
                    if ((bitcnt_q == 4'd0) && rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        shift_d  = {rx_s_q, shift_q[9:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == C_LAST_BIT) begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                data_d  = shift_q[8:1];
                ferr_d  = ~shift_q[9];
                rcv_d   = 1'b1;
                state_d = S_DAV;
            end
            S_DAV: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            ferr_q   <= 1'b0;
            rcv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            ferr_q   <= ferr_d;
            rcv_q    <= rcv_d;
        end
    end

    // rcv_q is high exactly while the FSM sits in DAV, with data/ferr already updated
    assign rcv  = rcv_q;
    assign data = data_q;
    assign ferr = ferr_q;

endmodule : uart_rx

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Randomised self-checking bench for uart_rx against a frame-level reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int B       = 16;
    localparam int NOMINAL = 2 + B / 2 + 9 * B + 2;

    typedef struct {
        logic [7:0] d;
        logic       f;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       rcv;
    logic [7:0] data;
    logic       ferr;
    logic       bg_ena = 1'b0;
    logic       bg_out;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    logic rcv_prev = 1'b0;
    exp_t exp_q[$];

    uart_rx #(
        .BAUDRATE (B)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .rcv  (rcv),
        .data (data),
        .ferr (ferr)
    );

    baudgen_rx #(
        .BAUDRATE (B)
    ) u_bg (
        .rstn    (rstn),
        .clk     (clk),
        .clk_ena (bg_ena),
        .clk_out (bg_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: every well-formed frame on the line yields one strobe
    // carrying its byte, ~stop as ferr, at the nominal latency from the start edge.
    always @(negedge clk) begin
        rcv_prev <= rcv;
        if (rcv) begin
            chk("rcv_width", 32'(rcv_prev), 32'(0));
            if (exp_q.size() == 0) begin
                chk("spurious_rcv", 32'(1), 32'(0));
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.t;
                chk("data", 32'(data), 32'(e.d));
                chk("ferr", 32'(ferr), 32'(e.f));
                chk("latency_in_window", 32'((lat >= NOMINAL - 2) && (lat <= NOMINAL + 2)), 32'(1));
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
        exp_t e;
        e.d = b;
        e.f = ~stop_bit;
        e.t = cyc;
        exp_q.push_back(e);
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(B);
        end
        rx = stop_bit;
        tick(B);
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        chk(tag, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [7:0] rb;
        logic       stop;

        tick(4);
        chk("reset_rcv", 32'(rcv), 32'(0));
        chk("reset_data", 32'(data), 32'(0));
        chk("reset_ferr", 32'(ferr), 32'(0));
        rstn = 1'b1;
        tick(2);

        // Baud generator on its own: pulses at 8, 24, 40 after enable
        bg_ena = 1'b1;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            chk("bg_pulse", 32'(bg_out), 32'((k % B) == (B / 2)));
        end
        tick(1);
        bg_ena = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bg_disabled", 32'(bg_out), 32'(0));
        end
        tick(1);
        bg_ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("bg_reenable", 32'(bg_out), 32'(k == (B / 2)));
        end
        tick(1);
        bg_ena = 1'b0;

        send_frame(8'h55, 1'b1, 20);
        drain("h55_done");

        send_frame(8'h41, 1'b1, 0);
        send_frame(8'h42, 1'b1, 20);
        drain("b2b_done");

        send_frame(8'hA5, 1'b0, 2 * B);
        send_frame(8'h3C, 1'b1, 20);
        drain("ferr_done");

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * B);
        chk("glitch_data", 32'(data), 32'(8'h3C));
        chk("glitch_ferr", 32'(ferr), 32'(0));
        send_frame(8'h81, 1'b1, 20);
        drain("after_glitch");

        // Reset in the middle of data bit 4, then the line returns to idle
        rb = 8'($urandom);
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            tick(B);
        end
        rx = rb[4];
        tick(B / 2);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        rx   = 1'b1;
        chk("midrst_data", 32'(data), 32'(0));
        chk("midrst_ferr", 32'(ferr), 32'(0));
        tick(4 * B);
        chk("midrst_hold_data", 32'(data), 32'(0));
        send_frame(8'hC3, 1'b1, 20);
        drain("after_midrst");

        for (int n = 0; n < 20; n++) begin
            rb   = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if (stop) begin
                send_frame(rb, 1'b1, int'($urandom_range(0, 2 * B)));
            end else begin
                send_frame(rb, 1'b0, B + int'($urandom_range(0, B)));
            end
        end
        drain("random_done");

        tick(2 * B);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_rx

`default_nettype wire
